// File: rtl/gray_counter.sv
// ---------------------------------------------------------------------------
// gray_counter
//
// Purpose:
//   Registered up/down counter that presents its count in Gray code and in
//   binary at the same time. The counter also accepts a parallel binary load.
//   It is intended for clock-domain-crossing FIFO pointers and position
//   encoders, where only one output bit may change per step.
//
// Parameters:
//   WIDTH  count width in bits (2..32)
//   INIT   binary count value applied by reset, truncated to WIDTH bits
//
// Ports:
//   clk       in   1      single clock, rising-edge active
//   rst       in   1      synchronous active-high reset
//   en        in   1      count enable, one step per cycle while high
//   up        in   1      direction (1 = increment, 0 = decrement)
//   load      in   1      parallel load strobe (has priority over en)
//   load_bin  in   WIDTH  binary value captured when load = 1
//   gray_out  out  WIDTH  registered Gray code of the count
//   bin_out   out  WIDTH  registered binary count
//   tc        out  1      registered terminal-count flag
//
// Configuration macro:
//   GRAY_COUNTER_SAT_EN
//     Undefined (default): the count wraps modulo 2^WIDTH. tc pulses for one
//       cycle after each wrapping step.
//     Defined: the count saturates at 0 and 2^WIDTH-1. A step that would
//       leave the range is blocked. tc is high for the cycle after every
//       blocked step.
// ---------------------------------------------------------------------------
module gray_counter #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned INIT  = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_bin,
   output logic [WIDTH-1:0] gray_out,
   output logic [WIDTH-1:0] bin_out,
   output logic             tc
);

   // The action the counter takes this cycle when it is not in reset.
   // Reset is handled directly in the register process.
   typedef enum logic [1:0] {
      OP_HOLD = 2'd0,
      OP_LOAD = 2'd1,
      OP_STEP = 2'd2
   } op_e;

   localparam logic [WIDTH-1:0] INIT_BIN  = INIT[WIDTH-1:0];
   localparam logic [WIDTH-1:0] INIT_GRAY = INIT_BIN ^ (INIT_BIN >> 1);
   localparam logic [WIDTH-1:0] ONE       = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] ALL_ONES  = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] ALL_ZEROS = {WIDTH{1'b0}};

   // Registered state. The Gray code has its own flop so that gray_out and
   // bin_out come straight from registers and switch on the same edge.
   logic [WIDTH-1:0] cnt_q,  cnt_d;
   logic [WIDTH-1:0] gray_q, gray_d;
   logic             tc_q,   tc_d;

   // Intermediate step logic.
   op_e              op;
   logic             at_max;
   logic             at_min;
   logic             boundary;
   logic [WIDTH-1:0] cnt_inc;
   logic [WIDTH-1:0] cnt_dec;
   logic [WIDTH-1:0] step_cnt;

   // Binary to reflected Gray code. Adjacent binary values always differ in
   // exactly one Gray bit. This includes the wrap between all-ones and zero.
   function automatic logic [WIDTH-1:0] bin_to_gray(input logic [WIDTH-1:0] b);
      return b ^ (b >> 1);
   endfunction

   // Decode the action for this cycle. load beats en, so a load cycle never
   // steps, whatever the state of en and up.
   always_comb begin
      op = OP_HOLD;
      if (load) begin
         op = OP_LOAD;
      end else if (en) begin
         op = OP_STEP;
      end
   end

   // Work out the candidate stepped count and detect the range boundary.
   // A "boundary" step is one that would wrap: up from all-ones, or down
   // from zero. In wrap mode the modular add/subtract already yields the
   // wrapped value. In saturating mode such a step is blocked and the count
   // is kept. Either way the boundary step raises tc on the next cycle.
   always_comb begin
      at_max   = (cnt_q == ALL_ONES);
      at_min   = (cnt_q == ALL_ZEROS);
      boundary = up ? at_max : at_min;
      cnt_inc  = cnt_q + ONE;
      cnt_dec  = cnt_q - ONE;
`ifdef GRAY_COUNTER_SAT_EN
      if (boundary) begin
         step_cnt = cnt_q;
      end else begin
         step_cnt = up ? cnt_inc : cnt_dec;
      end
`else
      step_cnt = up ? cnt_inc : cnt_dec;
`endif
   end

   // Next-state selection. By default the count and Gray code hold and tc
   // drops, because tc only marks the cycle straight after a boundary step.
   // The Gray code is derived from the next binary value. That way the
   // registered Gray output never lags the registered binary output.
   always_comb begin
      cnt_d  = cnt_q;
      gray_d = gray_q;
      tc_d   = 1'b0;
      case (op)
         OP_LOAD: begin
            cnt_d  = load_bin;
            gray_d = bin_to_gray(load_bin);
         end
         OP_STEP: begin
            cnt_d  = step_cnt;
            gray_d = bin_to_gray(step_cnt);
            tc_d   = boundary;
         end
         default: begin
            cnt_d  = cnt_q;
            gray_d = gray_q;
            tc_d   = 1'b0;
         end
      endcase
   end

   // State registers with synchronous reset. Reset wins over load and en.
   // It restores the INIT count together with its matching Gray code.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= INIT_BIN;
         gray_q <= INIT_GRAY;
         tc_q   <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         gray_q <= gray_d;
         tc_q   <= tc_d;
      end
   end

   // All outputs come directly from flops. No input reaches an output
   // through combinational logic.
   assign bin_out  = cnt_q;
   assign gray_out = gray_q;
   assign tc       = tc_q;

endmodule

// File: tb/tb_gray_counter.sv
// ---------------------------------------------------------------------------
// tb_gray_counter
//
// Self-checking bench for gray_counter (WIDTH = 4). A main instance uses
// INIT = 0. A second instance uses INIT = 9 and shares the same inputs, so
// its reset values can be checked. Every driven cycle pushes the expected
// outputs to a scoreboard queue. Once the DUT has registered that cycle,
// the entry is popped and compared. Directed scenarios add fixed expected
// constants. A random phase then exercises en/up/load/rst. Build with
// GRAY_COUNTER_SAT_EN defined to check the saturating variant.
// ---------------------------------------------------------------------------
module tb_gray_counter;

   localparam int W = 4;

   logic         clk;
   logic         rst;
   logic         en;
   logic         up;
   logic         load;
   logic [W-1:0] load_bin;
   logic [W-1:0] gray_out;
   logic [W-1:0] bin_out;
   logic         tc;
   logic [W-1:0] gray_out9;
   logic [W-1:0] bin_out9;
   logic         tc9;

   int tests_run;
   int tests_failed;

   // Reference model state.
   logic [W-1:0] m_cnt;
   logic         m_tc;

   typedef struct {
      logic [W-1:0] bin;
      logic [W-1:0] gray;
      logic         tc;
      logic         moved;
      logic [W-1:0] prev_gray;
   } exp_t;

   exp_t sb_q[$];

   gray_counter #(.WIDTH(W), .INIT(0)) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .up       (up),
      .load     (load),
      .load_bin (load_bin),
      .gray_out (gray_out),
      .bin_out  (bin_out),
      .tc       (tc)
   );

   gray_counter #(.WIDTH(W), .INIT(9)) dut9 (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .up       (up),
      .load     (load),
      .load_bin (load_bin),
      .gray_out (gray_out9),
      .bin_out  (bin_out9),
      .tc       (tc9)
   );

   // Free-running clock, 10 time-unit period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [W-1:0] to_gray(input logic [W-1:0] b);
      return b ^ (b >> 1);
   endfunction

   // Count one comparison. Report it if the observed value differs from
   // the expected one.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      tests_run++;
      if (observed !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   // Drive one cycle of inputs and step the reference model. The expected
   // result goes to the scoreboard. After the active edge, the oldest entry
   // is popped and checked against the DUT outputs.
   task automatic applyStimulus(input logic r, input logic e, input logic u,
                                input logic l, input logic [W-1:0] lb);
      exp_t         x;
      exp_t         got;
      logic         bnd;
      logic [W-1:0] old_cnt;
      @(negedge clk);
      rst      = r;
      en       = e;
      up       = u;
      load     = l;
      load_bin = lb;
      old_cnt  = m_cnt;
      x.prev_gray = to_gray(m_cnt);
      x.moved     = 1'b0;
      if (r) begin
         m_cnt = '0;
         m_tc  = 1'b0;
      end else if (l) begin
         m_cnt = lb;
         m_tc  = 1'b0;
      end else if (e) begin
         bnd = u ? (m_cnt == 4'hF) : (m_cnt == 4'h0);
`ifdef GRAY_COUNTER_SAT_EN
         if (!bnd) m_cnt = u ? m_cnt + 4'd1 : m_cnt - 4'd1;
`else
         m_cnt = u ? m_cnt + 4'd1 : m_cnt - 4'd1;
`endif
         m_tc    = bnd;
         x.moved = (m_cnt != old_cnt);
      end else begin
         m_tc = 1'b0;
      end
      x.bin  = m_cnt;
      x.gray = to_gray(m_cnt);
      x.tc   = m_tc;
      sb_q.push_back(x);
      @(posedge clk);
      #1;
      got = sb_q.pop_front();
      checkOutput("bin_out", 32'(bin_out), 32'(got.bin));
      checkOutput("gray_out", 32'(gray_out), 32'(got.gray));
      checkOutput("tc", 32'(tc), 32'(got.tc));
      if (got.moved) begin
         checkOutput("gray_one_bit", $countones(gray_out ^ got.prev_gray), 1);
      end
   endtask

   logic [W-1:0] walk_tab [16];

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      m_cnt        = '0;
      m_tc         = 1'b0;
      rst          = 1'b1;
      en           = 1'b0;
      up           = 1'b0;
      load         = 1'b0;
      load_bin     = '0;
      walk_tab = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                   4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

      // Reset state, including the INIT = 9 instance.
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 4'h0);
      checkOutput("rst_bin", 32'(bin_out), 32'h0);
      checkOutput("rst_gray", 32'(gray_out), 32'h0);
      checkOutput("rst_tc", 32'(tc), 32'h0);
      checkOutput("init9_bin", 32'(bin_out9), 32'h9);
      checkOutput("init9_gray", 32'(gray_out9), 32'hD);
      checkOutput("init9_tc", 32'(tc9), 32'h0);

      // Full up walk through the Gray sequence and back to zero.
      for (int i = 0; i < 16; i++) begin
         applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
         checkOutput("walk_gray", 32'(gray_out), 32'(walk_tab[(i + 1) % 16]));
         checkOutput("walk_tc", 32'(tc), (i == 15) ? 32'h1 : 32'h0);
      end

      // Hold cycle: outputs stay put and tc is low.
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
      checkOutput("hold_bin", 32'(bin_out), 32'h0);

`ifndef GRAY_COUNTER_SAT_EN
      // Down from zero wraps to all-ones.
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
      checkOutput("dnwrap_bin", 32'(bin_out), 32'hF);
      checkOutput("dnwrap_gray", 32'(gray_out), 32'h8);
      checkOutput("dnwrap_tc", 32'(tc), 32'h1);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
      checkOutput("dn2_bin", 32'(bin_out), 32'hE);
      checkOutput("dn2_gray", 32'(gray_out), 32'h9);
      checkOutput("dn2_tc", 32'(tc), 32'h0);
`endif

      // Load takes priority over en in the same cycle.
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 4'hA);
      checkOutput("load_bin", 32'(bin_out), 32'hA);
      checkOutput("load_gray", 32'(gray_out), 32'hF);
      checkOutput("load_tc", 32'(tc), 32'h0);
      // Loading the current value changes nothing.
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'hA);
      checkOutput("reload_gray", 32'(gray_out), 32'hF);

      // Count up to 5, then reset alongside en.
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'h0);
      for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
      checkOutput("five_gray", 32'(gray_out), 32'h7);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 4'h0);
      checkOutput("midrst_bin", 32'(bin_out), 32'h0);
      checkOutput("midrst_gray", 32'(gray_out), 32'h0);
      checkOutput("midrst9_gray", 32'(gray_out9), 32'hD);

      // Upper boundary behaviour for the configured mode.
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'hF);
`ifdef GRAY_COUNTER_SAT_EN
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
         checkOutput("sat_bin", 32'(bin_out), 32'hF);
         checkOutput("sat_gray", 32'(gray_out), 32'h8);
         checkOutput("sat_tc", 32'(tc), 32'h1);
      end
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
      checkOutput("sat_dn_bin", 32'(bin_out), 32'hE);
      checkOutput("sat_dn_gray", 32'(gray_out), 32'h9);
      checkOutput("sat_dn_tc", 32'(tc), 32'h0);
`else
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
      checkOutput("upwrap_bin", 32'(bin_out), 32'h0);
      checkOutput("upwrap_tc", 32'(tc), 32'h1);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
      checkOutput("postwrap_tc", 32'(tc), 32'h0);
`endif

      // Randomised en/up/load with occasional reset.
      for (int i = 0; i < 10000; i++) begin
         applyStimulus(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0,
                       ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                       ($urandom_range(0, 99) < 55) ? 1'b1 : 1'b0,
                       ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0,
                       W'($urandom_range(0, 15)));
      end

      checkOutput("scoreboard_empty", 32'(sb_q.size()), 32'h0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
